pueo_turf_trig_arb: RTL and testbench
=====================================

# pueo_turf_trig_arb

Arbitrates TURF-originated trigger requests (software, PPS, external) onto the single TURF trigger port of the master trigger processor. Each request is timestamped with the current trigger address and corrected by a per-source offset. Pending requests are granted round-robin, only in sysclk trigger slots, and with a programmable minimum spacing. It sits between the trigger control register block and the master trigger process, in the sysclk domain.

## Interface
- ADDR_BITS, 12, trigger address width (matches master trigger process address)
- HOLDOFF_BITS, 16, holdoff counter width
- sysclk_i  in  1  system clock; all logic in this domain
- sysclk_rst_n_i  in  1  asynchronous, active-low reset
- slot_ce_i  in  1  trigger slot qualifier (2 cycles per 8-clock command cycle)
- running_i  in  1  run active; low clears and blocks all pending work
- cur_addr_i  in  ADDR_BITS  current trigger buffer address
- soft_req_i / pps_req_i / ext_req_i  in  1 each  single-cycle request pulses
- soft_offset_i / pps_offset_i / ext_offset_i  in  ADDR_BITS each  quasi-static address offset per source
- holdoff_i  in  HOLDOFF_BITS  minimum sysclk cycles between issued triggers
- turf_trig_o  out  ADDR_BITS  issued trigger address
- turf_metadata_o  out  8  [7:6] source (01 soft, 10 pps, 11 ext), [5] drop flag, [4:0] sequence
- turf_valid_o  out  1  one-cycle strobe qualifying trig/metadata
- drop_count_o  out  16  saturating count of dropped requests
- busy_o  out  1  high when any request is pending or holdoff is active

## Operation
- Reset: all outputs 0, pending flags clear, RR pointer = soft, sequence = 0, state IDLE.
- Capture: request pulse at cycle t with running_i high sets that source's pending flag at t+1. It stores (cur_addr_i − offset) mod 2^ADDR_BITS sampled at t. Requests with running_i low are ignored and not counted.
- Drop: a request arriving while its source is already pending and not being granted that cycle is discarded. drop_count_o increments, saturating at 0xFFFF, and the source's drop flag is set. The flag clears when that source is next issued and is reported in metadata bit 5.
- Same-cycle grant and new request on one source: the grant consumes the old request, and the new request becomes pending. Not a drop.
- State machine:
  - IDLE: on slot_ce_i with any pending, grant the first pending source at or after the RR pointer (order soft→pps→ext). Go to ISSUE.
  - ISSUE: drive turf_valid_o with the granted data. Clear that pending flag. Advance the RR pointer to the source after the grantee. Increment sequence (mod 32). Load holdoff counter with holdoff_i. Go to HOLDOFF, or to IDLE if holdoff_i = 0.
  - HOLDOFF: decrement each cycle. On reaching 0, go to IDLE. Requests are still captured.
- running_i falling: all pending flags and drop flags clear and the state returns to IDLE the next cycle. A grant already in ISSUE completes. drop_count_o and sequence are retained and clear only on reset.
- Arithmetic: subtraction wraps modulo 2^ADDR_BITS. Holdoff is unsigned.

## Timing
- Request to earliest turf_valid_o: pulse at t with slot_ce_i at t+1 gives grant at t+1 and turf_valid_o at t+2.
- turf_valid_o is registered, exactly one cycle wide, and turf_trig_o/turf_metadata_o are stable during it. Outputs hold their last values otherwise; only valid is meaningful.
- Maximum one issue per slot_ce_i cycle. With holdoff_i = 0, back-to-back slots 4 cycles apart may each issue.
- Holdoff N: the next grant is possible no earlier than the first slot_ce_i at least N+1 cycles after ISSUE.
- Offsets and holdoff_i are sampled at use (capture / ISSUE respectively). No handshake is required.

## Structure
- Package pueo_trig_arb_pkg: source enum (SRC_SOFT=1, SRC_PPS=2, SRC_EXT=3), metadata bit positions, arbiter state enum.
- Sub-module pueo_trig_req_slot, instantiated 3×: pending flag, stored address, drop flag, drop pulse out.
- Top: RR grant, FSM, holdoff counter, sequence counter, drop counter.

## Test plan
- Single soft request, cur_addr 0x100, offset 0x010, slot_ce one cycle later -> turf_valid_o after 2 cycles, trig 0x0F0, metadata 0x40.
- Wrap: ext request, cur_addr 0x005, offset 0x00A -> trig 0xFFB, metadata 0xC0 | seq.
- All three requests in same cycle, holdoff 0 -> issues on three successive slots in order soft, pps, ext, with seq 0,1,2. Repeat the burst -> order starts at soft again (pointer after ext).
- pps requested twice while pending, holdoff 100 -> drop_count_o = 1, and the next pps issue has metadata bit 5 set. Force 70000 drops -> drop_count_o = 0xFFFF.
- running_i dropped with two pending -> no turf_valid_o afterwards, busy_o low within 1 cycle. Requests with running_i low -> ignored, no drop counted.
- Assert sysclk_rst_n_i mid-HOLDOFF -> all outputs 0 immediately. A post-reset request is issued with seq 0.

Source files
------------

// File: rtl/pueo_trig_arb_pkg.sv
// pueo_trig_arb_pkg: shared types and helpers for the TURF trigger arbiter
package pueo_trig_arb_pkg;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_SOFT = 2'd1, SRC_PPS = 2'd2, SRC_EXT = 2'd3} src_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLDOFF} state_e;
  localparam int META_SRC_LSB = 6;
  localparam int META_DROP = 5;
  localparam int META_SEQ_BITS = 5;
  function automatic src_e src_next(input src_e s);
    return (s == SRC_EXT) ? SRC_SOFT : src_e'(s + 2'd1);
  endfunction
  function automatic src_e rr_pick(input logic [2:0] pend, input src_e rr);
    src_e s;
    src_e r;
    s = rr;
    r = SRC_NONE;
    for (int k = 0; k < 3; k++) begin
      if (r == SRC_NONE && pend[s - 2'd1]) r = s;
      s = src_next(s);
    end
    return r;
  endfunction
endpackage

// File: rtl/pueo_trig_req_slot.sv
// pueo_trig_req_slot: one source's pending request, captured address and drop tracking
module pueo_trig_req_slot #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 sysclk_i,
  input  logic                 sysclk_rst_n_i,
  input  logic                 running_i,
  input  logic                 req_i,
  input  logic                 grant_i,
  input  logic [ADDR_BITS-1:0] cur_addr_i,
  input  logic [ADDR_BITS-1:0] offset_i,
  output logic                 pending_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 drop_flag_o,
  output logic                 drop_o
);
  logic pend_q, pend_d, dflag_q, dflag_d, capture;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  // A grant frees the slot in the same cycle, so a coincident request is accepted rather than dropped
  always_comb begin
    capture = running_i & req_i & (~pend_q | grant_i);
    drop_o = running_i & req_i & pend_q & ~grant_i;
    pend_d = running_i & (req_i | (pend_q & ~grant_i));
    dflag_d = running_i & (drop_o | (dflag_q & ~grant_i));
    addr_d = capture ? cur_addr_i - offset_i : addr_q;
  end
  // Slot state register
  always_ff @(posedge sysclk_i or negedge sysclk_rst_n_i) begin
    if (!sysclk_rst_n_i) begin
      pend_q <= 1'b0;
      dflag_q <= 1'b0;
      addr_q <= '0;
    end else begin
      pend_q <= pend_d;
      dflag_q <= dflag_d;
      addr_q <= addr_d;
    end
  end
  assign pending_o = pend_q;
  assign addr_o = addr_q;
  assign drop_flag_o = dflag_q;
endmodule

// File: rtl/pueo_turf_trig_arb.sv
// pueo_turf_trig_arb: round-robin, slot-aligned, holdoff-spaced arbiter for TURF trigger sources
module pueo_turf_trig_arb
  import pueo_trig_arb_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int HOLDOFF_BITS = 16
) (
  input  logic                    sysclk_i,
  input  logic                    sysclk_rst_n_i,
  input  logic                    slot_ce_i,
  input  logic                    running_i,
  input  logic [ADDR_BITS-1:0]    cur_addr_i,
  input  logic                    soft_req_i,
  input  logic                    pps_req_i,
  input  logic                    ext_req_i,
  input  logic [ADDR_BITS-1:0]    soft_offset_i,
  input  logic [ADDR_BITS-1:0]    pps_offset_i,
  input  logic [ADDR_BITS-1:0]    ext_offset_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  output logic [ADDR_BITS-1:0]    turf_trig_o,
  output logic [7:0]              turf_metadata_o,
  output logic                    turf_valid_o,
  output logic [15:0]             drop_count_o,
  output logic                    busy_o
);
  logic [2:0] req, pend, dflag, drop, gnt;
  logic [ADDR_BITS-1:0] addr [3];
  logic [ADDR_BITS-1:0] offs [3];
  logic [ADDR_BITS-1:0] sel_addr, trig_q, trig_d;
  logic [7:0] meta_q, meta_d;
  logic valid_q, valid_d, sel_drop;
  logic [META_SEQ_BITS-1:0] seq_q, seq_d;
  logic [HOLDOFF_BITS-1:0] cnt_q, cnt_d;
  logic [15:0] dc_q;
  logic [16:0] dc_sum;
  logic [1:0] drop_n;
  src_e gnt_src, rr_q, rr_d;
  state_e state_q, state_d;
  assign req = {ext_req_i, pps_req_i, soft_req_i};
  assign offs = '{soft_offset_i, pps_offset_i, ext_offset_i};
  for (genvar i = 0; i < 3; i++) begin : g_slot
    pueo_trig_req_slot #(.ADDR_BITS(ADDR_BITS)) u_slot (
      .sysclk_i(sysclk_i),
      .sysclk_rst_n_i(sysclk_rst_n_i),
      .running_i(running_i),
      .req_i(req[i]),
      .grant_i(gnt[i]),
      .cur_addr_i(cur_addr_i),
      .offset_i(offs[i]),
      .pending_o(pend[i]),
      .addr_o(addr[i]),
      .drop_flag_o(dflag[i]),
      .drop_o(drop[i])
    );
    assign gnt[i] = gnt_src == src_e'(2'(i + 1));
  end
  assign gnt_src = (state_q == ST_IDLE && slot_ce_i && running_i) ? rr_pick(pend, rr_q) : SRC_NONE;
  assign sel_addr = gnt[0] ? addr[0] : gnt[1] ? addr[1] : addr[2];
  assign sel_drop = |(gnt & dflag);
  assign drop_n = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
  assign dc_sum = {1'b0, dc_q} + 17'(drop_n);
  // Grant latches the outgoing trigger so ISSUE presents it registered; holdoff is sampled in ISSUE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    valid_d = 1'b0;
    trig_d = trig_q;
    meta_d = meta_q;
    rr_d = rr_q;
    seq_d = seq_q;
    case (state_q)
      ST_IDLE: if (gnt_src != SRC_NONE) begin
        valid_d = 1'b1;
        trig_d = sel_addr;
        meta_d = {gnt_src, sel_drop, seq_q};
        rr_d = src_next(gnt_src);
        seq_d = seq_q + 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d = holdoff_i;
        state_d = (holdoff_i == '0 || !running_i) ? ST_IDLE : ST_HOLDOFF;
      end
      default: begin
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q <= 1 || !running_i) ? ST_IDLE : ST_HOLDOFF;
      end
    endcase
  end
  // Arbiter, output and counter registers
  always_ff @(posedge sysclk_i or negedge sysclk_rst_n_i) begin
    if (!sysclk_rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      valid_q <= 1'b0;
      trig_q <= '0;
      meta_q <= '0;
      rr_q <= SRC_SOFT;
      seq_q <= '0;
      dc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      trig_q <= trig_d;
      meta_q <= meta_d;
      rr_q <= rr_d;
      seq_q <= seq_d;
      dc_q <= dc_sum[16] ? 16'hFFFF : dc_sum[15:0];
    end
  end
  assign turf_trig_o = trig_q;
  assign turf_metadata_o = meta_q;
  assign turf_valid_o = valid_q;
  assign drop_count_o = dc_q;
  assign busy_o = |pend | (state_q != ST_IDLE);
endmodule

// File: tb/tb_pueo_turf_trig_arb.sv
// tb_pueo_turf_trig_arb: scoreboard bench for the TURF trigger arbiter
module tb_pueo_turf_trig_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slot_ce = 1'b0, running = 1'b1;
  logic [11:0] cur_addr = '0;
  logic soft_req = 1'b0, pps_req = 1'b0, ext_req = 1'b0;
  logic [11:0] soft_off = '0, pps_off = '0, ext_off = '0;
  logic [15:0] holdoff = '0;
  logic [11:0] trig;
  logic [7:0] meta;
  logic valid, busy;
  logic [15:0] dc;
  logic [19:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  pueo_turf_trig_arb dut (
    .sysclk_i(clk),
    .sysclk_rst_n_i(rst_n),
    .slot_ce_i(slot_ce),
    .running_i(running),
    .cur_addr_i(cur_addr),
    .soft_req_i(soft_req),
    .pps_req_i(pps_req),
    .ext_req_i(ext_req),
    .soft_offset_i(soft_off),
    .pps_offset_i(pps_off),
    .ext_offset_i(ext_off),
    .holdoff_i(holdoff),
    .turf_trig_o(trig),
    .turf_metadata_o(meta),
    .turf_valid_o(valid),
    .drop_count_o(dc),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid got trig=%h meta=%h, expected no issue", trig, meta);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({trig, meta} !== e) begin
          fails++;
          $display("FAIL issue got trig=%h meta=%h expected trig=%h meta=%h", trig, meta, e[19:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic slot();
    slot_ce = 1'b1;
    tick();
    slot_ce = 1'b0;
    idle(3);
  endtask

  task automatic reqs(input logic s, input logic p, input logic e);
    soft_req = s;
    pps_req = p;
    ext_req = e;
    tick();
    soft_req = 1'b0;
    pps_req = 1'b0;
    ext_req = 1'b0;
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_trig", 32'(trig), 32'h0);
    check("rst_meta", 32'(meta), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_drops", 32'(dc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick();
    // single soft request, latency check
    cur_addr = 12'h100;
    soft_off = 12'h010;
    exp_q.push_back({12'h0F0, 8'h40});
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    slot_ce = 1'b1;
    @(negedge clk);
    check("lat_grant_cycle_valid", 32'(valid), 32'h0);
    tick();
    slot_ce = 1'b0;
    @(negedge clk);
    check("lat_issue_cycle_valid", 32'(valid), 32'h1);
    idle(3);
    // address wrap on ext
    cur_addr = 12'h005;
    ext_off = 12'h00A;
    exp_q.push_back({12'hFFB, 8'hC1});
    reqs(0, 0, 1);
    slot();
    // two simultaneous bursts, round robin restarts at soft
    soft_off = 12'h010;
    pps_off = 12'h020;
    ext_off = 12'h030;
    cur_addr = 12'h200;
    exp_q.push_back({12'h1F0, 8'h42});
    exp_q.push_back({12'h1E0, 8'h83});
    exp_q.push_back({12'h1D0, 8'hC4});
    reqs(1, 1, 1);
    slot();
    slot();
    slot();
    cur_addr = 12'h300;
    exp_q.push_back({12'h2F0, 8'h45});
    exp_q.push_back({12'h2E0, 8'h86});
    exp_q.push_back({12'h2D0, 8'hC7});
    reqs(1, 1, 1);
    slot();
    slot();
    slot();
    // drop on pps during holdoff
    holdoff = 16'd100;
    cur_addr = 12'h400;
    exp_q.push_back({12'h3F0, 8'h48});
    reqs(1, 0, 0);
    slot();
    @(negedge clk);
    check("busy_in_holdoff", 32'(busy), 32'h1);
    cur_addr = 12'h410;
    reqs(0, 1, 0);
    cur_addr = 12'h500;
    reqs(0, 1, 0);
    @(negedge clk);
    check("drop_count_one", 32'(dc), 32'h1);
    exp_q.push_back({12'h3F0, 8'hA9});
    idle(110);
    slot();
    // running low clears pending and ignores requests
    reqs(1, 0, 1);
    running = 1'b0;
    tick();
    @(negedge clk);
    check("busy_after_stop", 32'(busy), 32'h0);
    slot();
    reqs(1, 0, 0);
    reqs(1, 0, 0);
    @(negedge clk);
    check("drops_ignored_stopped", 32'(dc), 32'h1);
    check("busy_stopped_reqs", 32'(busy), 32'h0);
    running = 1'b1;
    tick();
    slot();
    check("busy_after_restart", 32'(busy), 32'h0);
    // saturate the drop counter
    holdoff = 16'd50;
    cur_addr = 12'h600;
    soft_req = 1'b1;
    pps_req = 1'b1;
    ext_req = 1'b1;
    idle(24000);
    soft_req = 1'b0;
    pps_req = 1'b0;
    ext_req = 1'b0;
    @(negedge clk);
    check("drop_count_sat", 32'(dc), 32'hFFFF);
    exp_q.push_back({12'h5D0, 8'hEA});
    slot();
    @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'h1);
    // asynchronous reset mid-holdoff
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_trig", 32'(trig), 32'h0);
    check("arst_meta", 32'(meta), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_drops", 32'(dc), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    idle(2);
    rst_n = 1'b1;
    tick();
    cur_addr = 12'h700;
    exp_q.push_back({12'h6F0, 8'h40});
    reqs(1, 0, 0);
    slot();
    idle(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
